// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-master round-robin arbiter with region protection in front of the memory controller
module mem_port_arbiter #(
    parameter logic [31:0] ROM_END = 32'd152099,
    parameter logic [31:0] RAM_END = 32'd305735,
    parameter logic [31:0] IO_ADDR = 32'd305736
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wd,
    output logic        m0_ack,
    output logic        m0_rvalid,
    output logic [31:0] m0_rd,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wd,
    output logic        m1_ack,
    output logic        m1_rvalid,
    output logic [31:0] m1_rd,
    output logic        m1_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        last_gnt;
    logic        lat_id;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wd;
    logic [31:0] rsp_rd;
    logic        gnt_valid;
    logic        gnt_id;
    logic        is_ram;
    logic        is_oom;
    logic        illegal;

    // Pick a winner: a lone requester wins; on a tie the master not granted last time wins.
    always_comb begin
        gnt_valid = m0_req | m1_req;
        gnt_id    = 1'b0;
        if (m0_req && m1_req) begin
            gnt_id = ~last_gnt;
        end else begin
            gnt_id = m1_req;
        end
    end

    // Classify the latched address; writes only land in RAM and anything past the IO word is out of map.
    always_comb begin
        is_ram  = (lat_addr > ROM_END) && (lat_addr <= RAM_END);
        is_oom  = (lat_addr > IO_ADDR);
        illegal = (lat_we && !is_ram) || is_oom;
    end

    // Next-state and all port outputs; memory port is only driven while issuing.
    always_comb begin
        state_nxt = state;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        m0_rd     = 32'd0;
        m1_rd     = 32'd0;
        m0_err    = 1'b0;
        m1_err    = 1'b0;
        mem_addr  = 32'd0;
        mem_wd    = 32'd0;
        mem_we    = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (gnt_valid) begin
                    m0_ack    = ~gnt_id;
                    m1_ack    = gnt_id;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_addr  = lat_addr;
                mem_wd    = lat_wd;
                mem_we    = lat_we && !illegal;
                state_nxt = DONE;
            end
            DONE: begin
                if (lat_id) begin
                    m1_rvalid = 1'b1;
                    m1_rd     = rsp_rd;
                    m1_err    = illegal;
                end else begin
                    m0_rvalid = 1'b1;
                    m0_rd     = rsp_rd;
                    m0_err    = illegal;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, request latch and response capture; reset drops any pending transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            lat_id   <= 1'b0;
            lat_we   <= 1'b0;
            lat_addr <= 32'd0;
            lat_wd   <= 32'd0;
            rsp_rd   <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && gnt_valid) begin
                lat_id   <= gnt_id;
                last_gnt <= gnt_id;
                lat_we   <= gnt_id ? m1_we : m0_we;
                lat_addr <= gnt_id ? m1_addr : m0_addr;
                lat_wd   <= gnt_id ? m1_wd : m0_wd;
            end
            if (state == ISSUE) begin
                rsp_rd <= (!lat_we && !illegal) ? mem_rd : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_we, m0_ack, m0_rvalid, m0_err;
    logic [31:0] m0_addr, m0_wd, m0_rd;
    logic        m1_req, m1_we, m1_ack, m1_rvalid, m1_err;
    logic [31:0] m1_addr, m1_wd, m1_rd;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic        mem_we;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
        .m0_ack(m0_ack), .m0_rvalid(m0_rvalid), .m0_rd(m0_rd), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
        .m1_ack(m1_ack), .m1_rvalid(m1_rvalid), .m1_rd(m1_rd), .m1_err(m1_err),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory controller model: read data tags the low address bits.
    always_comb mem_rd = {16'hDEAD, mem_addr[15:0]};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input bit m, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input bit exp_mem_we, input logic [31:0] exp_rd, input bit exp_err);
        if (m) begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wd = wd;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wd = wd;
        end
        #1;
        check("ack_winner", m ? m1_ack : m0_ack, 32'd1);
        check("ack_other", m ? m0_ack : m1_ack, 32'd0);
        tick();
        m0_req = 1'b0;
        m1_req = 1'b0;
        check("issue_busy", busy, 32'd1);
        check("issue_ack", {31'd0, m0_ack | m1_ack}, 32'd0);
        check("issue_addr", mem_addr, addr);
        check("issue_wd", mem_wd, wd);
        check("issue_we", mem_we, exp_mem_we);
        tick();
        check("done_rvalid", m ? m1_rvalid : m0_rvalid, 32'd1);
        check("done_other_rvalid", m ? m0_rvalid : m1_rvalid, 32'd0);
        check("done_rd", m ? m1_rd : m0_rd, exp_rd);
        check("done_err", m ? m1_err : m0_err, exp_err);
        check("done_mem_we", mem_we, 32'd0);
        check("done_mem_addr", mem_addr, 32'd0);
        tick();
        check("idle_busy", busy, 32'd0);
        check("idle_rvalid", {31'd0, m0_rvalid | m1_rvalid}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'd0; m0_wd = 32'd0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'd0; m1_wd = 32'd0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_busy", busy, 32'd0);
        check("rst_rvalid", {31'd0, m0_rvalid | m1_rvalid}, 32'd0);
        check("rst_err", {31'd0, m0_err | m1_err}, 32'd0);
        check("rst_rd0", m0_rd, 32'd0);
        check("rst_rd1", m1_rd, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wd", mem_wd, 32'd0);
        check("rst_mem_we", mem_we, 32'd0);

        // Plain read, legal write at first RAM byte, blocked writes, region boundaries.
        do_txn(1'b0, 1'b0, 32'd100, 32'd0, 1'b0, 32'hDEAD0064, 1'b0);
        do_txn(1'b1, 1'b1, 32'd152100, 32'h12345678, 1'b1, 32'd0, 1'b0);
        do_txn(1'b0, 1'b1, 32'd5, 32'hAAAA5555, 1'b0, 32'd0, 1'b1);
        do_txn(1'b0, 1'b1, 32'd305736, 32'h00000001, 1'b0, 32'd0, 1'b1);
        do_txn(1'b0, 1'b1, 32'd152099, 32'h0000BEEF, 1'b0, 32'd0, 1'b1);
        do_txn(1'b1, 1'b1, 32'd305735, 32'hCAFEF00D, 1'b1, 32'd0, 1'b0);
        do_txn(1'b0, 1'b0, 32'd305736, 32'd0, 1'b0, 32'hDEADAA48, 1'b0);
        do_txn(1'b1, 1'b0, 32'd400000, 32'd0, 1'b0, 32'd0, 1'b1);
        do_txn(1'b1, 1'b0, 32'd305737, 32'd0, 1'b0, 32'd0, 1'b1);

        // Both masters request continuously from reset: m0, m1, m0, m1.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100; m0_wd = 32'd0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h200; m1_wd = 32'd0;
        #1;
        for (int c = 0; c < 12; c++) begin
            int slot;
            bit who;
            slot = c % 3;
            who  = ((c / 3) % 2) == 1;
            check("rr_m0_ack", m0_ack, (slot == 0 && !who) ? 32'd1 : 32'd0);
            check("rr_m1_ack", m1_ack, (slot == 0 && who) ? 32'd1 : 32'd0);
            check("rr_m0_rvalid", m0_rvalid, (slot == 2 && !who) ? 32'd1 : 32'd0);
            check("rr_m1_rvalid", m1_rvalid, (slot == 2 && who) ? 32'd1 : 32'd0);
            if (slot == 2) begin
                check("rr_rd", who ? m1_rd : m0_rd, who ? 32'hDEAD0200 : 32'hDEAD0100);
            end
            tick();
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();

        // Reset lands during ISSUE of a legal write.
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'd200000; m0_wd = 32'h55AA55AA;
        #1;
        check("rst6_ack", m0_ack, 32'd1);
        tick();
        m0_req = 1'b0;
        check("rst6_issue_we", mem_we, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst6_mem_we", mem_we, 32'd0);
        check("rst6_busy", busy, 32'd0);
        check("rst6_no_rvalid", m0_rvalid, 32'd0);
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd300; m1_wd = 32'd0;
        #1;
        check("rst6_m1_ack", m1_ack, 32'd1);
        tick();
        m1_req = 1'b0;
        check("rst6_m1_issue_addr", mem_addr, 32'd300);
        check("rst6_still_no_rvalid", m0_rvalid, 32'd0);
        tick();
        check("rst6_m1_rvalid", m1_rvalid, 32'd1);
        check("rst6_m1_rd", m1_rd, 32'hDEAD012C);
        check("rst6_m0_quiet", m0_rvalid, 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
